// File: rtl/sqrt_iter_unit.sv
// Iterative floor(sqrt) engine using odd-number accumulation: the running square
// (k+1)^2 is advanced by 2k+3 until it passes the captured operand.
module sqrt_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH:0]     square
);

  localparam int RW = WIDTH / 2;
  localparam int DW = RW + 2;
  localparam int SW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TEST   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WIDTH-1:0] r_a;
  logic [SW-1:0]   r_s;
  logic [DW-1:0]   r_d;
  logic [RW-1:0]   r_root;
  logic            w_le;

  // Square still within the operand: keep accumulating.
  function automatic logic f_square_le(input logic [SW-1:0] s, input logic [WIDTH-1:0] a);
    return s <= {1'b0, a};
  endfunction

  // Increment is 2k+3 on exit, so k = (d >> 1) - 1; always fits RW bits.
  function automatic logic [RW-1:0] f_root_from_inc(input logic [DW-1:0] d);
    return RW'((d >> 1) - DW'(1));
  endfunction

  assign w_le = f_square_le(r_s, r_a);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = TEST;
      TEST:    w_next = w_le ? UPDATE : DONE;
      UPDATE:  w_next = TEST;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      IDLE:    busy = 1'b0;
      TEST,
      UPDATE:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_s    <= SW'(1);
      r_d    <= DW'(3);
      r_root <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a <= operand;
            r_s <= SW'(1);
            r_d <= DW'(3);
          end
        end
        TEST: begin
          if (!w_le) r_root <= f_root_from_inc(r_d);
        end
        UPDATE: begin
          r_s <= r_s + SW'(r_d);
          r_d <= r_d + DW'(2);
        end
        default: begin
          r_a <= r_a;
        end
      endcase
    end
  end

  assign root   = r_root;
  assign square = r_s;

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Self-checking bench for sqrt_iter_unit: directed table, protocol/reset sequences
// and random operands against a plain floor-sqrt reference.
module tb_sqrt_iter_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] operand;
  logic        busy;
  logic        done;
  logic [7:0]  root;
  logic [16:0] square;

  int n_cmp = 0;
  int n_bad = 0;

  sqrt_iter_unit #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .root    (root),
    .square  (square)
  );

  always #5 clock = ~clock;

  typedef struct {
    int op;
    int exp_root;
    int exp_edges;
    int exp_sq;
  } vec_t;

  vec_t vecs[8];

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts one operation from IDLE (called #1 after an edge); optionally pulses
  // start with operand=100 for one cycle after edge pulse_at of the run.
  task automatic run_op(input int op, input int pulse_at, output int r, output int e,
                        output int sq);
    int n = 0;
    bit got = 0;
    start   = 1'b1;
    operand = 16'(op);
    @(posedge clock); #1;
    start   = 1'b0;
    operand = 16'($urandom);
    chk("busy_after_accept", busy, 1);
    while (n < 600 && !got) begin
      @(posedge clock);
      n++;
      #1;
      if (done) got = 1;
      else if (n == pulse_at) begin
        start   = 1'b1;
        operand = 16'd100;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("busy_with_done", busy, 1);
    r  = root;
    e  = n;
    sq = square;
    @(posedge clock); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_fall_after_done", busy, 0);
  endtask

  task automatic check_model(input string tag, input int op, input int r, input int e,
                             input int sq);
    int k = isqrt(op);
    chk({tag, "_root"}, r, k);
    chk({tag, "_edges"}, e, 2 * k + 1);
    chk({tag, "_square"}, sq, (k + 1) * (k + 1));
  endtask

  initial begin
    int r, e, sq, op, n, dones;
    bit got;

    vecs[0] = '{0,     0,   1,   1};
    vecs[1] = '{1,     1,   3,   4};
    vecs[2] = '{4,     2,   5,   9};
    vecs[3] = '{50,    7,   15,  64};
    vecs[4] = '{65535, 255, 511, 65536};
    vecs[5] = '{3,     1,   3,   4};
    vecs[6] = '{15,    3,   7,   16};
    vecs[7] = '{16,    4,   9,   25};

    reset   = 1'b1;
    start   = 1'b0;
    operand = 16'd0;
    #3;
    chk("rst_square", square, 1);
    chk("rst_root", root, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("idle_busy", busy, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, -1, r, e, sq);
      chk($sformatf("vec%0d_root", i), r, vecs[i].exp_root);
      chk($sformatf("vec%0d_edges", i), e, vecs[i].exp_edges);
      chk($sformatf("vec%0d_square", i), sq, vecs[i].exp_sq);
    end

    // start while busy is ignored, then a fresh request is honoured
    run_op(9, 2, r, e, sq);
    chk("busy_start_ignored_root", r, 3);
    chk("busy_start_ignored_edges", e, 7);
    run_op(100, -1, r, e, sq);
    chk("fresh_100_root", r, 10);

    // start held high: restart on the first IDLE edge after DONE
    start   = 1'b1;
    operand = 16'd25;
    @(posedge clock); #1;
    n = 0; got = 0;
    while (n < 600 && !got) begin
      @(posedge clock); n++; #1;
      if (done) got = 1;
    end
    chk("held_done_seen", got, 1);
    chk("held_root", root, 5);
    @(posedge clock); #1;
    chk("held_idle_gap_busy", busy, 0);
    @(posedge clock); #1;
    chk("held_reaccept_busy", busy, 1);
    start = 1'b0;
    n = 0; got = 0;
    while (n < 600 && !got) begin
      @(posedge clock); n++; #1;
      if (done) got = 1;
    end
    chk("held_second_done", got, 1);
    chk("held_second_root", root, 5);
    @(posedge clock); #1;

    // asynchronous reset mid-computation
    start   = 1'b1;
    operand = 16'd40000;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("abort_root", root, 0);
    chk("abort_square", square, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 450; i++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_op(16, -1, r, e, sq);
    chk("after_abort_root", r, 4);

    // random operands against the reference model
    for (int i = 0; i < 90; i++) begin
      op = (i % 2 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 65535));
      run_op(op, -1, r, e, sq);
      check_model($sformatf("rand%0d_op%0d", i, op), op, r, e, sq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
